// File: rtl/regram_port_arbiter.sv
// Round-robin arbiter sharing RAM port s2 among NUM_REQ requesters.
// Routes read data back to the issuing requester and supports locked read-modify-write.
module regram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk_currctrl_sys_ram_clk,
    input  logic                             reset_currctrl_sys_ram_reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]        req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]    req_byteenable,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic [ADDR_W-1:0]                ram_address,
    output logic                             ram_chipselect,
    output logic                             ram_clken,
    output logic                             ram_write,
    output logic [DATA_W-1:0]                ram_writedata,
    output logic [(DATA_W/8)-1:0]            ram_byteenable,
    input  logic [DATA_W-1:0]                ram_readdata,
    output logic                             lock_owner_valid
);
    // Lock FSM
    //   state       | meaning
    //   ST_UNLOCKED | round-robin among all requesters
    //   ST_LOCKED   | only r_owner may be granted; r_tmo counts owner idle cycles down

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] TMO_LOAD = 4'd15;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

    lock_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_owner, w_owner_nxt;
    logic [3:0]           r_tmo, w_tmo_nxt;
    logic [IDX_W-1:0]     r_last_grant;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_found;
    logic [NUM_REQ-1:0]   w_ready;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata_arr [NUM_REQ];
    logic [BE_W-1:0]      w_be_arr    [NUM_REQ];

    logic                 r_cs, r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [BE_W-1:0]      r_be;
    logic [RD_LATENCY:0]  r_tag_v;
    logic [IDX_W-1:0]     r_tag_id [RD_LATENCY+1];
    logic [DATA_W-1:0]    r_rdata_hold;
    logic                 w_rsp_fire;

    always_comb begin : p_unpack
        for (int i = 0; i < NUM_REQ; i++) begin
            w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
            w_be_arr[i]    = req_byteenable[i*BE_W +: BE_W];
        end
    end

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin : p_arb
        logic [IDX_W-1:0] cand;
        cand        = '0;
        w_gnt_idx   = '0;
        w_gnt_found = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_gnt_idx   = r_owner;
            w_gnt_found = req_valid[r_owner];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
                if (!w_gnt_found && req_valid[cand]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = cand;
                end
            end
        end
        w_ready = '0;
        if (w_gnt_found) w_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin : p_lock_nxt
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_gnt_found && req_lock[w_gnt_idx]) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_gnt_idx;
                    w_tmo_nxt   = TMO_LOAD;
                end
            end
            ST_LOCKED: begin
                if (w_gnt_found) begin
                    if (!req_lock[w_gnt_idx]) w_state_nxt = ST_UNLOCKED;
                    else                      w_tmo_nxt   = TMO_LOAD;
                end else if (r_tmo == 4'd0) begin
                    w_state_nxt = ST_UNLOCKED;
                end else begin
                    w_tmo_nxt = r_tmo - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_currctrl_sys_ram_clk or negedge reset_currctrl_sys_ram_reset_n) begin
        if (!reset_currctrl_sys_ram_reset_n) begin
            r_state <= ST_UNLOCKED;
            r_owner <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_ff @(posedge clk_currctrl_sys_ram_clk or negedge reset_currctrl_sys_ram_reset_n) begin
        if (!reset_currctrl_sys_ram_reset_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_tag_v      <= '0;
            r_rdata_hold <= '0;
            for (int s = 0; s <= RD_LATENCY; s++) r_tag_id[s] <= '0;
        end else begin
            r_cs <= w_gnt_found;
            r_we <= w_gnt_found & req_write[w_gnt_idx];
            if (w_gnt_found) begin
                r_last_grant <= w_gnt_idx;
                r_addr       <= w_addr_arr[w_gnt_idx];
                r_wdata      <= w_wdata_arr[w_gnt_idx];
                r_be         <= w_be_arr[w_gnt_idx];
            end
            // Stage 0 lines up with ram_chipselect; the last stage with ram_readdata.
            r_tag_v     <= {r_tag_v[RD_LATENCY-1:0], w_gnt_found & ~req_write[w_gnt_idx]};
            r_tag_id[0] <= w_gnt_idx;
            for (int s = 1; s <= RD_LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
            if (w_rsp_fire) r_rdata_hold <= ram_readdata;
        end
    end

    assign w_rsp_fire = r_tag_v[RD_LATENCY];

    always_comb begin : p_rsp
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = w_rsp_fire && (r_tag_id[RD_LATENCY] == IDX_W'(i));
    end

    assign req_ready        = w_ready;
    assign rsp_rdata        = w_rsp_fire ? ram_readdata : r_rdata_hold;
    assign ram_address      = r_addr;
    assign ram_chipselect   = r_cs;
    assign ram_clken        = 1'b1;
    assign ram_write        = r_we;
    assign ram_writedata    = r_wdata;
    assign ram_byteenable   = r_be;
    assign lock_owner_valid = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_regram_port_arbiter.sv
// Bench for regram_port_arbiter: vector table, directed corner cases and a random run
// checked against a transaction-level model; a second instance exercises RD_LATENCY=3.
module tb_regram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*BW-1:0] req_be;

    logic [N-1:0]  rdy1, rv1, rdy3, rv3;
    logic [DW-1:0] rd1, wd1, rdd1, rd3, wd3, rdd3;
    logic [AW-1:0] ra1, ra3;
    logic [BW-1:0] be1, be3;
    logic          cs1, ck1, we1, lov1, cs3, ck3, we3, lov3;

    regram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut1 (
        .clk_currctrl_sys_ram_clk(clk), .reset_currctrl_sys_ram_reset_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteenable(req_be),
        .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1),
        .ram_address(ra1), .ram_chipselect(cs1), .ram_clken(ck1), .ram_write(we1),
        .ram_writedata(wd1), .ram_byteenable(be1), .ram_readdata(rdd1),
        .lock_owner_valid(lov1));

    regram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
        .clk_currctrl_sys_ram_clk(clk), .reset_currctrl_sys_ram_reset_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteenable(req_be),
        .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rd3),
        .ram_address(ra3), .ram_chipselect(cs3), .ram_clken(ck3), .ram_write(we3),
        .ram_writedata(wd3), .ram_byteenable(be3), .ram_readdata(rdd3),
        .lock_owner_valid(lov3));

    function automatic logic [31:0] ini(input int i);
        if (i == 16) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Behavioural RAMs; non-read cycles put junk on readdata.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rdp1;
    logic [31:0] rdp3 [3];
    assign rdd1 = rdp1;
    assign rdd3 = rdp3[2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] <= ini(i);
            mem3[i] <= ini(i);
        end
        forever begin
            @(posedge clk);
            if (cs1 && we1) mem1[ra1] <= merge(mem1[ra1], wd1, be1);
            rdp1 <= (cs1 && !we1) ? mem1[ra1] : $urandom;
            if (cs3 && we3) mem3[ra3] <= merge(mem3[ra3], wd3, be3);
            rdp3[0] <= (cs3 && !we3) ? mem3[ra3] : $urandom;
            rdp3[1] <= rdp3[0];
            rdp3[2] <= rdp3[1];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of the RTL-1 instance.
    typedef struct {int due; int id; logic [31:0] data;} rsp_t;
    rsp_t        rq[$];
    logic [31:0] shadow [256];
    int          m_last, m_owner, m_idle, cyc;
    logic        m_cs, m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wd, m_hold;
    logic [3:0]  m_be;

    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_wd;
    logic [N*BW-1:0] p_be;

    task automatic model_reset();
        m_last = N - 1; m_owner = -1; m_idle = 0;
        m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_be = '0; m_hold = '0;
        rq.delete();
    endtask

    task automatic check_regs();
        logic [3:0]  erv;
        logic [31:0] erd;
        erv = '0;
        erd = m_hold;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv = 4'(1 << rq[0].id);
            erd = rq[0].data;
            m_hold = erd;
            void'(rq.pop_front());
        end
        chk("chipselect", 64'(cs1), 64'(m_cs));
        chk("write", 64'(we1), 64'(m_we));
        chk("address", 64'(ra1), 64'(m_addr));
        chk("writedata", 64'(wd1), 64'(m_wd));
        chk("byteenable", 64'(be1), 64'(m_be));
        chk("rsp_valid", 64'(rv1), 64'(erv));
        chk("rsp_rdata", 64'(rd1), 64'(erd));
        chk("lock_owner_valid", 64'(lov1), 64'(m_owner >= 0));
        chk("clken", 64'(ck1), 64'd1);
    endtask

    task automatic model_cycle();
        int g;
        g = -1;
        if (m_owner >= 0) begin
            if (req_valid[m_owner[1:0]]) g = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (g < 0 && req_valid[j[1:0]]) g = j;
            end
        end
        chk("req_ready", 64'(rdy1), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            m_cs   = 1'b1;
            m_we   = req_write[g[1:0]];
            m_addr = req_addr[g*AW +: AW];
            m_wd   = req_wdata[g*DW +: DW];
            m_be   = req_be[g*BW +: BW];
            if (m_we) shadow[m_addr] = merge(shadow[m_addr], m_wd, m_be);
            else      rq.push_back('{due: cyc + 2, id: g, data: shadow[m_addr]});
            m_last = g;
            if (m_owner < 0) begin
                if (req_lock[g[1:0]]) begin m_owner = g; m_idle = 0; end
            end else if (!req_lock[g[1:0]]) begin
                m_owner = -1;
            end else begin
                m_idle = 0;
            end
        end else begin
            m_cs = 1'b0;
            m_we = 1'b0;
            if (m_owner >= 0) begin
                m_idle++;
                if (m_idle == 16) m_owner = -1;
            end
        end
        cyc++;
    endtask

    task automatic rand_payload(input int base, input int span);
        for (int i = 0; i < N; i++) begin
            p_addr[i*AW +: AW] = AW'(base + int'($urandom_range(0, span - 1)));
            p_wd[i*DW +: DW]   = $urandom;
            p_be[i*BW +: BW]   = 4'($urandom);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [3:0] lk);
        @(posedge clk);
        #1;
        check_regs();
        req_valid = v; req_write = w; req_lock = lk;
        req_addr = p_addr; req_wdata = p_wd; req_be = p_be;
        #1;
        model_cycle();
    endtask

    typedef struct {logic [3:0] v; logic [3:0] w; logic [3:0] lk; logic [3:0] rdy; logic lov;} vec_t;
    vec_t tbl [20];

    initial begin
        logic [3:0] mask, v, lk;
        tbl[0]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1010, 4'b0000, 4'b1000, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0101, 4'b0000, 4'b0001, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b0};
        tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[9]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[10] = '{4'b0101, 4'b1111, 4'b0000, 4'b0100, 1'b0};
        tbl[11] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[12] = '{4'b0110, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[13] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0};
        tbl[14] = '{4'b1011, 4'b0000, 4'b0010, 4'b0010, 1'b1};
        tbl[15] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        tbl[16] = '{4'b1011, 4'b0010, 4'b0000, 4'b0010, 1'b1};
        tbl[17] = '{4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[18] = '{4'b1001, 4'b1111, 4'b0000, 4'b0001, 1'b0};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        for (int i = 0; i < 256; i++) shadow[i] = ini(i);
        model_reset();
        cyc = 0;
        req_valid = '0; req_write = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        rand_payload(8'h30, 16);

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clken", 64'(ck1), 64'd1);
        chk("rst_cs", 64'(cs1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cs", 64'(cs1), 64'd0);
        chk("idle_ready", 64'(rdy1), 64'd0);
        chk("idle_rsp_valid", 64'(rv1), 64'd0);
        chk("idle_clken", 64'(ck1), 64'd1);

        foreach (tbl[i]) begin
            rand_payload(8'h30, 16);
            step(tbl[i].v, tbl[i].w, tbl[i].lk);
            chk($sformatf("tbl%0d_ready", i), 64'(rdy1), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_lock", i), 64'(lov1), 64'(tbl[i].lov));
        end
        repeat (3) step(4'b0000, 4'b0000, 4'b0000);

        // Requester 2 reads 0x10 holding 0xDEADBEEF
        rand_payload(8'h30, 16);
        p_addr[2*AW +: AW] = 8'h10;
        step(4'b0100, 4'b0000, 4'b0000);
        chk("rd_ready", 64'(rdy1), 64'b0100);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("rd_cs", 64'(cs1), 64'd1);
        chk("rd_addr", 64'(ra1), 64'h10);
        chk("rd_rsp_early", 64'(rv1), 64'd0);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("rd_rsp_valid", 64'(rv1), 64'b0100);
        chk("rd_rsp_data", 64'(rd1), 64'hDEAD_BEEF);
        chk("rd3_rsp_early2", 64'(rv3), 64'd0);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("rd3_rsp_early3", 64'(rv3), 64'd0);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("rd3_rsp_valid", 64'(rv3), 64'b0100);
        chk("rd3_rsp_data", 64'(rd3), 64'hDEAD_BEEF);

        // Locked read-modify-write by requester 1 while 0 and 3 wait
        rand_payload(8'h30, 16);
        step(4'b0010, 4'b0000, 4'b0010);
        chk("lk_ready_rd", 64'(rdy1), 64'b0010);
        step(4'b1001, 4'b0000, 4'b0000);
        chk("lk_stall", 64'(rdy1), 64'd0);
        chk("lk_held", 64'(lov1), 64'd1);
        p_addr[1*AW +: AW] = 8'h20;
        p_be[1*BW +: BW]   = 4'b0011;
        step(4'b1011, 4'b0010, 4'b0000);
        chk("lk_ready_wr", 64'(rdy1), 64'b0010);
        step(4'b1001, 4'b0000, 4'b0000);
        chk("lk_after_ready", 64'(rdy1), 64'b1000);
        chk("lk_released", 64'(lov1), 64'd0);
        chk("lk_wr_write", 64'(we1), 64'd1);
        chk("lk_wr_addr", 64'(ra1), 64'h20);
        chk("lk_wr_be", 64'(be1), 64'b0011);

        // Requester 3 locks then goes quiet; requester 0 waits out the timeout
        step(4'b1000, 4'b0000, 4'b1000);
        chk("to_ready3", 64'(rdy1), 64'b1000);
        for (int c = 0; c < 16; c++) begin
            step(4'b0001, 4'b0000, 4'b0000);
            chk($sformatf("to_stall%0d", c), 64'(rdy1), 64'd0);
            chk($sformatf("to_lock%0d", c), 64'(lov1), 64'd1);
        end
        step(4'b0001, 4'b0000, 4'b0000);
        chk("to_ready0", 64'(rdy1), 64'b0001);
        chk("to_unlocked", 64'(lov1), 64'd0);

        // Random traffic against the model
        mask = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            if (c % 24 == 0) mask = 4'($urandom);
            v  = 4'($urandom) & mask;
            lk = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rand_payload(0, 16);
            step(v, 4'($urandom), lk);
        end
        repeat (20) step(4'b0000, 4'b0000, 4'b0000);

        // Reset while reads from 0 and 1 are in flight
        rand_payload(0, 16);
        step(4'b0001, 4'b0000, 4'b0000);
        chk("rif_ready0", 64'(rdy1), 64'b0001);
        step(4'b0010, 4'b0000, 4'b0000);
        chk("rif_ready1", 64'(rdy1), 64'b0010);
        @(posedge clk);
        #1;
        check_regs();
        cyc++;
        #1;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_lock = '0;
        model_reset();
        #1;
        chk("rif_rst_rsp_valid", 64'(rv3), 64'd0);
        chk("rif_rst_cs", 64'(cs3), 64'd0);
        chk("rif_rst_addr", 64'(ra3), 64'd0);
        chk("rif_rst_write", 64'(we3), 64'd0);
        chk("rif_rst_wdata", 64'(wd3), 64'd0);
        chk("rif_rst_be", 64'(be3), 64'd0);
        chk("rif_rst_rdata", 64'(rd3), 64'd0);
        chk("rif_rst_lock", 64'(lov3), 64'd0);
        chk("rif_rst_clken", 64'(ck3), 64'd1);
        chk("rif_rst_ready", 64'(rdy3), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(4'b0000, 4'b0000, 4'b0000);
            chk($sformatf("rif_rsp3_%0d", c), 64'(rv3), 64'd0);
            chk($sformatf("rif_rsp1_%0d", c), 64'(rv1), 64'd0);
        end
        chk("rif_post_rdata3", 64'(rd3), 64'd0);
        chk("rif_post_cs3", 64'(cs3), 64'd0);
        step(4'b0000, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regram_port_arbiter.md
Name: regram_port_arbiter

Overview:
Round-robin arbiter that shares one port (s2) of the current-control register RAM among NUM_REQ on-chip requesters, such as the per-coil current loops and the readback sequencer.
It registers the winning command onto the RAM port and tracks outstanding reads through a fixed-latency pipeline. Read data is returned to the requester that issued the read.
A lock mechanism gives atomic read-modify-write sequences.
The block sits in the RAM clock domain, between the requesters and currctrl_register_ram_s2_*.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, RAM word address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
RD_LATENCY, 1, cycles from ram_chipselect to valid ram_readdata (1..3)

Ports:
clk_currctrl_sys_ram_clk  in  1  clock
reset_currctrl_sys_ram_reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  keep grant after this command
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
req_byteenable  in  NUM_REQ*DATA_W/8  flattened byte enables
req_ready  out  NUM_REQ  one-hot accept (combinational)
rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse
rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
ram_address  out  ADDR_W  to RAM s2 address
ram_chipselect  out  1  to RAM s2 chipselect
ram_clken  out  1  to RAM s2 clken
ram_write  out  1  to RAM s2 write
ram_writedata  out  DATA_W  to RAM s2 writedata
ram_byteenable  out  DATA_W/8  to RAM s2 byteenable
ram_readdata  in  DATA_W  from RAM s2 readdata
lock_owner_valid  out  1  a lock is currently held (status)

Behaviour:
- Reset (async assert, sync release): all outputs 0 except ram_clken=1. Round-robin pointer starts so requester 0 has highest priority. Lock is cleared and the read pipeline is flushed.
- ram_clken is tied high after reset.
- Arbitration is combinational within the cycle:
  - Unlocked: req_ready is one-hot to the first requester with req_valid, searching from (last_grant+1) mod NUM_REQ upward with wrap-around. If no requester is valid, req_ready=0.
  - Locked: only the lock owner can receive req_ready. Other requesters stall regardless of their req_valid.
- Accept occurs when req_valid[i] & req_ready[i].
- On accept:
  - last_grant <= i.
  - Next cycle: ram_chipselect=1 for exactly one cycle; ram_address, ram_write, ram_writedata and ram_byteenable carry the registered command.
- When no command is accepted: ram_chipselect=0, ram_write=0, and the data/address outputs hold their last value.
- Throughput: one command per cycle; back-to-back grants are allowed.
- Fairness: with all requesters continuously valid and no locks, each requester is granted once per NUM_REQ cycles.
- Lock handling:
  - Accepting a command with req_lock[i]=1 sets lock owner = i and lock_owner_valid=1 from the next cycle.
  - Accepting a command from the owner with req_lock=0 releases the lock from the next cycle; that command itself is still executed.
  - The lock is also released if the owner drops req_valid for 16 consecutive cycles (timeout counter resets on each owner accept).
- Reads:
  - For each accepted read, a tag (requester index plus valid bit) enters a RD_LATENCY-deep shift pipeline aligned with ram_chipselect.
  - rsp_valid[tag] pulses for 1 cycle, exactly 1+RD_LATENCY cycles after the accept cycle. rsp_rdata = ram_readdata in that cycle.
  - rsp_rdata holds its value when no response is being returned.
  - Writes produce no response.
- Ordering: responses return in acceptance order. A read accepted the cycle after a write to the same address returns the new data, because the RAM is serial.
- Byte enables pass through unmodified. A read command also drives its byteenable onto ram_byteenable; the RAM ignores it.
- Reset mid-operation: in-flight read tags are discarded and no rsp_valid is produced after reset deassertion.
- Concurrent events:
  - Lock release and another requester's request in the same cycle: the other request waits until the next cycle; it is granted then if it is next in round-robin order.
  - Timeout expiry and an owner request in the same cycle: the owner request is accepted and the timeout is cancelled.

Test Plan:
- Reset then idle → ram_chipselect=0, req_ready=0, rsp_valid=0, ram_clken=1.
- Requester 2 reads addr 0x10 (RAM holds 0xDEADBEEF), RD_LATENCY=1 → ram_chipselect at cycle+1 with ram_address=0x10; rsp_valid=4'b0100 at cycle+2; rsp_rdata=0xDEADBEEF.
- All 4 requesters hold valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each requester gets exactly 2 accepts; ram_chipselect stays high for cycles 1..8.
- Requester 1 performs a read with lock=1, then a write with lock=0 to 0x20 (byteenable=4'b0011), while requesters 0 and 3 are valid → neither 0 nor 3 is granted until after the unlocking write. The RAM write carries byteenable 4'b0011.
- Requester 3 takes a lock then drops req_valid → lock_owner_valid falls after 16 cycles; requester 0's pending request is then granted.
- Issue reads from requesters 0 and 1, and assert reset while they are in flight, with RD_LATENCY=3 → no rsp_valid after reset release; all outputs at their reset values.
